mem_byte_responder: RTL and testbench



---
 rtl/mem_byte_responder_if.sv | 25 ++
 rtl/mem_byte_responder.sv | 130 +++++++++++++
 tb/tb_mem_byte_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_responder_if.sv
// Request/response bus between the core (master) and the byte-serial memory responder (slave).
interface mem_byte_responder_if #(
    parameter int ADDR_W = 15
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_byte_responder.sv
// Byte-serial memory responder: turns one byte/half/word request into little-endian
// single-byte accesses on a synchronous RAM port and returns one response per request.
module mem_byte_responder #(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_byte_responder_if.slave bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wren,
    input  logic [7:0]        ram_q
);
    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("mem_byte_responder: RD_LAT must be 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, RESP} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        k_reg, k_next;
    logic [1:0]        last_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    logic [1:0]        last_req;
    logic              bad_req;

    // Index of the final byte, plus size/alignment legality of the incoming request.
    always_comb begin
        last_req = 2'd0;
        bad_req  = 1'b0;
        case (bus.req_size)
            2'd0:    last_req = 2'd0;
            2'd1:    begin last_req = 2'd1; bad_req = bus.req_addr[0];      end
            2'd2:    begin last_req = 2'd3; bad_req = |bus.req_addr[1:0];   end
            default: bad_req = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            k_reg     <= 2'd0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        ram_addr      = '0;
        ram_wdata     = 8'd0;
        ram_wren      = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = bad_req ? RESP : ACC;
                    k_next     = 2'd0;
                end
            end
            ACC: begin
                ram_addr = base_reg + ADDR_W'(k_reg);
                if (we_reg) begin
                    ram_wren  = 1'b1;
                    ram_wdata = wdata_reg[{k_reg, 3'b000} +: 8];
                end
                if (k_reg == last_reg) begin
                    state_next = we_reg ? RESP : DRAIN;
                end else begin
                    k_next = k_reg + 2'd1;
                end
            end
            DRAIN: state_next = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and read-byte assembly; ram_q lags ram_addr by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_reg  <= 2'd0;
            we_reg    <= 1'b0;
            base_reg  <= '0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        last_reg  <= last_req;
                        we_reg    <= bus.req_we;
                        base_reg  <= bus.req_addr;
                        wdata_reg <= bus.req_wdata;
                        rdata_reg <= 32'd0;
                        err_reg   <= bad_req;
                    end
                end
                ACC: begin
                    if (!we_reg && (k_reg != 2'd0)) begin
                        rdata_reg[{k_reg - 2'd1, 3'b000} +: 8] <= ram_q;
                    end
                end
                DRAIN: rdata_reg[{k_reg, 3'b000} +: 8] <= ram_q;
                default: ;
            endcase
        end
    end

    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;
endmodule

// File: tb/tb_mem_byte_responder.sv
// Directed-vector and scoreboard bench for mem_byte_responder with a byte-wide RAM model.
module tb_mem_byte_responder;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock;
    logic              reset_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_wren;
    logic [7:0]        ram_q;

    mem_byte_responder_if #(.ADDR_W(ADDR_W)) bus ();

    mem_byte_responder #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte RAM with one-cycle registered read.
    logic [7:0] ram_mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 8'd0;
        ram_q = 8'd0;
        forever begin
            @(posedge clock);
            if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
            ram_q <= ram_mem[ram_addr];
        end
    end

    int wren_cnt  = 0;
    int stray_cnt = 0;
    int acc_cnt   = 0;
    int rsp_cnt   = 0;
    always @(posedge clock) begin
        if (ram_wren) wren_cnt++;
        if (!ram_wren && ram_wdata != 8'd0) stray_cnt++;
        if (reset_n && bus.req_valid && bus.req_ready) acc_cnt++;
        if (reset_n && bus.rsp_valid && bus.rsp_ready) rsp_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input int stall,
                          output logic [31:0] rdata, output logic err, output int lat, output int wrens);
        int   tmo;
        int   w0;
        logic unstable;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tmo = 0;
        while (!bus.req_ready && tmo < 20) begin
            @(negedge clock);
            tmo++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        w0 = wren_cnt;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'd0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        if (!bus.rsp_valid) check("rsp_valid_timeout", 32'd0, 32'd1);
        rdata    = bus.rsp_rdata;
        err      = bus.rsp_err;
        unstable = 1'b0;
        for (int s = 0; s < stall; s++) begin
            // Offer another request while stalled; it must not be taken.
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_size  = 2'd0;
            @(negedge clock);
            if (!bus.rsp_valid || bus.rsp_rdata !== rdata || bus.rsp_err !== err || bus.req_ready)
                unstable = 1'b1;
        end
        if (stall > 0) check("rsp_hold_stable", 32'(unstable), 32'd0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        wrens = wren_cnt - w0;
        check("idle_after_rsp", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
    endtask

    typedef struct {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                stall;
        logic [31:0]       exp_rdata;
        logic              exp_err;
        int                exp_lat;
        int                exp_wrens;
    } vec_t;

    vec_t vecs [15];
    logic [7:0] sb_mem [0:DEPTH-1];

    initial begin
        logic [31:0]       rdata;
        logic              err;
        int                lat;
        int                wrens;
        int                acc0;
        int                rsp0;
        logic              r_we;
        logic [1:0]        r_size;
        logic [ADDR_W-1:0] r_addr;
        logic [31:0]       r_wdata;
        int                r_n;
        logic              r_err;
        logic [31:0]       r_exp;
        logic [ADDR_W-1:0] a;

        vecs[0]  = '{1'b1, 2'd2, 15'h0100, 32'h11223344, 0, 32'h0,        1'b0, 5, 4};
        vecs[1]  = '{1'b0, 2'd2, 15'h0100, 32'h0,        5, 32'h11223344, 1'b0, 6, 0};
        vecs[2]  = '{1'b0, 2'd0, 15'h0103, 32'h0,        0, 32'h00000011, 1'b0, 3, 0};
        vecs[3]  = '{1'b0, 2'd1, 15'h0102, 32'h0,        1, 32'h00001122, 1'b0, 4, 0};
        vecs[4]  = '{1'b0, 2'd1, 15'h0101, 32'h0,        0, 32'h0,        1'b1, 1, 0};
        vecs[5]  = '{1'b1, 2'd2, 15'h7FFC, 32'hA5B6C7D8, 0, 32'h0,        1'b0, 5, 4};
        vecs[6]  = '{1'b0, 2'd2, 15'h7FFC, 32'h0,        2, 32'hA5B6C7D8, 1'b0, 6, 0};
        vecs[7]  = '{1'b0, 2'd3, 15'h0200, 32'h0,        0, 32'h0,        1'b1, 1, 0};
        vecs[8]  = '{1'b1, 2'd0, 15'h7FFF, 32'h000000EE, 0, 32'h0,        1'b0, 2, 1};
        vecs[9]  = '{1'b0, 2'd2, 15'h7FFC, 32'h0,        0, 32'hEEB6C7D8, 1'b0, 6, 0};
        vecs[10] = '{1'b0, 2'd2, 15'h0102, 32'h0,        0, 32'h0,        1'b1, 1, 0};
        vecs[11] = '{1'b1, 2'd1, 15'h0202, 32'h0000BEEF, 0, 32'h0,        1'b0, 3, 2};
        vecs[12] = '{1'b0, 2'd1, 15'h0202, 32'h0,        0, 32'h0000BEEF, 1'b0, 4, 0};
        vecs[13] = '{1'b1, 2'd2, 15'h0105, 32'h12345678, 0, 32'h0,        1'b1, 1, 0};
        vecs[14] = '{1'b0, 2'd0, 15'h0201, 32'h0,        0, 32'h0,        1'b0, 3, 0};

        for (int i = 0; i < DEPTH; i++) sb_mem[i] = 8'd0;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        reset_n       = 1'b0;
        #12;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("reset_ram_out",   32'({ram_addr, ram_wdata, ram_wren}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors
        for (int v = 0; v < 15; v++) begin
            do_req(vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wdata, vecs[v].stall,
                   rdata, err, lat, wrens);
            check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("v%0d_err", v),   32'(err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_lat", v),   lat, vecs[v].exp_lat);
            check($sformatf("v%0d_wrens", v), wrens, vecs[v].exp_wrens);
        end
        check("t1_ram_bytes", {ram_mem[15'h0103], ram_mem[15'h0102], ram_mem[15'h0101], ram_mem[15'h0100]},
              32'h11223344);
        check("stall_no_accept", 32'(acc_cnt - rsp_cnt), 32'd0);

        // Reset during the second ACC cycle of a word write
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 15'h0300;
        bus.req_wdata = 32'h44332211;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("t5_wren_k1", 32'({ram_wren, ram_addr}), 32'({1'b1, 15'h0301}));
        reset_n = 1'b0;
        #1;
        check("t5_wren_async_drop", 32'(ram_wren), 32'd0);
        repeat (3) @(negedge clock);
        check("t5_no_rsp_in_reset", 32'(bus.rsp_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("t5_idle_after_reset", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
        check("t5_ram_bytes", {ram_mem[15'h0303], ram_mem[15'h0302], ram_mem[15'h0301], ram_mem[15'h0300]},
              32'h00000011);
        do_req(1'b0, 2'd2, 15'h0300, 32'd0, 0, rdata, err, lat, wrens);
        check("t5_readback", rdata, 32'h00000011);
        check("t5_readback_lat", lat, 6);

        // Random back-to-back requests against the scoreboard
        acc0 = acc_cnt;
        rsp0 = rsp_cnt;
        for (int t = 0; t < 40; t++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = 15'h0400 + 15'($urandom_range(0, 31));
            r_wdata = $urandom;
            r_n     = (r_size == 2'd0) ? 1 : (r_size == 2'd1) ? 2 : 4;
            r_err   = (r_size == 2'd3) || (r_size == 2'd1 && r_addr[0]) ||
                      (r_size == 2'd2 && r_addr[1:0] != 2'd0);
            r_exp   = 32'd0;
            if (!r_err && !r_we) begin
                for (int k = 0; k < r_n; k++) begin
                    a = r_addr + 15'(k);
                    r_exp[8*k +: 8] = sb_mem[a];
                end
            end
            do_req(r_we, r_size, r_addr, r_wdata, int'($urandom_range(0, 3)), rdata, err, lat, wrens);
            check($sformatf("t6_%0d_rdata", t), rdata, r_exp);
            check($sformatf("t6_%0d_err", t), 32'(err), 32'(r_err));
            check($sformatf("t6_%0d_lat", t), lat, r_err ? 1 : (r_we ? r_n + 1 : r_n + 2));
            check($sformatf("t6_%0d_wrens", t), wrens, (r_err || !r_we) ? 0 : r_n);
            if (!r_err && r_we) begin
                for (int k = 0; k < r_n; k++) begin
                    a = r_addr + 15'(k);
                    sb_mem[a] = r_wdata[8*k +: 8];
                end
            end
        end
        check("t6_accepts", acc_cnt - acc0, 40);
        check("t6_responses", rsp_cnt - rsp0, 40);
        check("stray_wdata", stray_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
